// File: rtl/result_uart_tx.sv
// Frame-buffered 8N1 UART transmitter for the systolic array's result words.
// Buffers N_WORDS results, then sends a header byte followed by every word, MSB byte first.
module result_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          N_WORDS      = 16,
  parameter int          WORD_W       = 16,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WORD_W-1:0]          result_in,
  input  logic                       result_valid,
  output logic                       TxD,
  output logic                       tx_busy,
  output logic                       frame_done,
  output logic                       overflow,
  output logic [$clog2(N_WORDS):0]   words_held
);

  localparam int IDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int CNT_W  = $clog2(N_WORDS) + 1;
  localparam int BPW    = WORD_W / 8;
  localparam int BSEL_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_WORDS);
  localparam logic [BSEL_W-1:0] BSEL_MAX = BSEL_W'(BPW - 1);

  typedef enum logic [1:0] {S_COLLECT, S_SEND, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [WORD_W-1:0]   r_buf [N_WORDS];
  logic [CNT_W-1:0]    r_words;
  logic [CNT_W-1:0]    r_widx;
  logic [BSEL_W-1:0]   r_bsel;
  logic [BAUD_W-1:0]   r_baud;
  logic [3:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_txd, r_busy, r_done, r_ovf;

  logic                w_fill, w_bit_end, w_byte_end, w_last;
  logic [WORD_W-1:0]   w_word;
  logic [7:0]          w_next_byte;

  assign w_fill      = (r_state == S_COLLECT) && result_valid && (r_words == CNT_LAST);
  assign w_bit_end   = (r_baud == BAUD_MAX);
  assign w_byte_end  = w_bit_end && (r_bit == 4'd9);
  // r_widx points at the next word to load, so it reaches N_WORDS once the last byte is in flight
  assign w_last      = (r_widx == CNT_FULL);
  assign w_word      = r_buf[r_widx[IDX_W-1:0]];
  assign w_next_byte = w_word[(BPW - 1 - int'(r_bsel)) * 8 +: 8];

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_COLLECT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: if (w_fill) w_next = S_SEND;
      S_SEND:    if (w_byte_end && w_last) w_next = S_DONE;
      S_DONE:    w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  // Buffer storage needs no reset; words_held alone says what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == S_COLLECT) && result_valid)
      r_buf[r_words[IDX_W-1:0]] <= result_in;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_words <= '0;
      r_widx  <= '0;
      r_bsel  <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (result_valid) r_words <= r_words + 1'b1;
          if (w_fill) begin
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_shift <= HDR_BYTE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_widx  <= '0;
            r_bsel  <= '0;
          end
        end
        S_SEND: begin
          if (result_valid) r_ovf <= 1'b1;
          if (!w_bit_end) begin
            r_baud <= r_baud + 1'b1;
          end else begin
            r_baud <= '0;
            if (r_bit < 4'd8) begin
              r_txd   <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 1'b1;
            end else if (r_bit == 4'd8) begin
              r_txd <= 1'b1;
              r_bit <= 4'd9;
            end else if (w_last) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              // Next byte starts immediately: no idle time between bytes
              r_txd   <= 1'b0;
              r_bit   <= '0;
              r_shift <= w_next_byte;
              if (r_bsel == BSEL_MAX) begin
                r_bsel <= '0;
                r_widx <= r_widx + 1'b1;
              end else begin
                r_bsel <= r_bsel + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (result_valid) r_ovf <= 1'b1;
          r_words <= '0;
        end
        default: ;
      endcase
    end
  end

  assign TxD        = r_txd;
  assign tx_busy    = r_busy;
  assign frame_done = r_done;
  assign overflow   = r_ovf;
  assign words_held = r_words;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with CLKS_PER_BIT=4: frame content, bit timing,
// overflow, sparse input and mid-frame reset.
module tb_result_uart_tx;
  localparam int CPB = 4;
  localparam int NW  = 16;
  localparam int NB  = 1 + NW * 2;
  localparam int FL  = NB * 10 * CPB;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] result_in = '0;
  logic        result_valid = 1'b0;
  logic        TxD, tx_busy, frame_done, overflow;
  logic [4:0]  words_held;

  int n_pass = 0;
  int n_chk  = 0;

  logic [15:0] wv [NW];
  logic [7:0]  rx_bytes [NB];
  logic        rx_wave [FL];
  logic [7:0]  exp_b;
  int          busy_err, done_err, idle_err, held_err;
  logic        done_seen;

  always #5 CLK = ~CLK;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .N_WORDS(NW), .WORD_W(16), .HDR_BYTE(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .result_in(result_in), .result_valid(result_valid),
    .TxD(TxD), .tx_busy(tx_busy), .frame_done(frame_done), .overflow(overflow),
    .words_held(words_held)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Strobe wv[0..15] with 'gap' idle cycles between strobes; ends one cycle after the 16th capture.
  task automatic send_words(input int gap);
    idle_err = 0;
    held_err = 0;
    for (int i = 0; i < NW; i++) begin
      result_in    = wv[i];
      result_valid = 1'b1;
      step();
      result_valid = 1'b0;
      if (words_held !== 5'(i + 1) && i < NW - 1) held_err++;
      if (i < NW - 1) begin
        if (TxD !== 1'b1) idle_err++;
        for (int g = 0; g < gap; g++) begin
          step();
          if (TxD !== 1'b1 || tx_busy !== 1'b0) idle_err++;
        end
      end
    end
  endtask

  // Records the whole frame starting at the current (start-bit) cycle; optionally injects two strobes.
  task automatic rx_frame(input int inj_a, input int inj_b);
    int bi;
    busy_err = 0;
    done_err = 0;
    for (int t = 0; t < FL; t++) begin
      rx_wave[t] = TxD;
      if (tx_busy !== 1'b1) busy_err++;
      if (frame_done !== 1'b0) done_err++;
      if (t % CPB == CPB / 2) begin
        bi = (t / CPB) % 10;
        if (bi >= 1 && bi <= 8) rx_bytes[t / (10 * CPB)][bi - 1] = TxD;
      end
      result_in    = 16'hDEAD;
      result_valid = (t == inj_a) || (t == inj_b);
      step();
    end
    result_valid = 1'b0;
    done_seen = frame_done;
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [15:0] w;
    if (k == 0) return 8'hA5;
    w = wv[(k - 1) / 2];
    return ((k % 2) == 1) ? w[15:8] : w[7:0];
  endfunction

  task automatic test_reset();
    int bad;
    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    n_chk++; if (TxD !== 1'b1) $display("FAIL reset_txd got %b want 1", TxD); else n_pass++;
    n_chk++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
    n_chk++; if (words_held !== 5'd0) $display("FAIL reset_held got %0d want 0", words_held); else n_pass++;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (TxD !== 1'b1 || frame_done !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL reset_idle got %0d bad cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_single_frame();
    int bad;
    for (int i = 0; i < NW; i++) wv[i] = 16'(i + 1);
    send_words(0);
    n_chk++; if (TxD !== 1'b0) $display("FAIL frame_start got %b want 0", TxD); else n_pass++;
    n_chk++; if (held_err != 0) $display("FAIL frame_held got %0d errs want 0", held_err); else n_pass++;
    n_chk++; if (words_held !== 5'd16) $display("FAIL frame_full got %0d want 16", words_held); else n_pass++;
    rx_frame(-1, -1);
    bad = 0;
    for (int k = 0; k < NB; k++) begin
      exp_b = exp_byte(k);
      n_chk++;
      if (rx_bytes[k] !== exp_b) begin
        $display("FAIL frame_byte%0d got %h want %h", k, rx_bytes[k], exp_b);
        bad++;
      end else n_pass++;
    end
    n_chk++; if (busy_err != 0) $display("FAIL frame_busy got %0d low cycles want 0", busy_err); else n_pass++;
    n_chk++; if (done_err != 0) $display("FAIL frame_done_early got %0d want 0", done_err); else n_pass++;
    n_chk++; if (done_seen !== 1'b1) $display("FAIL frame_done_1320 got %b want 1", done_seen); else n_pass++;
    n_chk++; if (tx_busy !== 1'b0) $display("FAIL frame_busy_end got %b want 0", tx_busy); else n_pass++;
    step();
    n_chk++; if (frame_done !== 1'b0) $display("FAIL frame_done_pulse got %b want 0", frame_done); else n_pass++;
    n_chk++; if (words_held !== 5'd0) $display("FAIL frame_held_clr got %0d want 0", words_held); else n_pass++;
  endtask

  task automatic test_bit_timing();
    logic exp_lvl;
    int   bad;
    wv[0] = 16'h55AA;
    for (int i = 1; i < NW; i++) wv[i] = 16'h0000;
    send_words(0);
    rx_frame(-1, -1);
    bad = 0;
    // second byte occupies cycles 40..79; levels 0,1,0,1,... for 0x55 with start/stop
    for (int t = 0; t < 10 * CPB; t++) begin
      exp_lvl = ((t / CPB) % 2) == 1;
      if (rx_wave[10 * CPB + t] !== exp_lvl) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL timing_wave got %0d bad cycles want 0", bad); else n_pass++;
    n_chk++; if (rx_bytes[1] !== 8'h55) $display("FAIL timing_b1 got %h want 55", rx_bytes[1]); else n_pass++;
    n_chk++; if (rx_bytes[2] !== 8'hAA) $display("FAIL timing_b2 got %h want aa", rx_bytes[2]); else n_pass++;
    n_chk++; if (done_seen !== 1'b1) $display("FAIL timing_done got %b want 1", done_seen); else n_pass++;
    step();
  endtask

  task automatic test_sparse();
    for (int i = 0; i < NW; i++) wv[i] = 16'h0100 + 16'(i);
    send_words(6);
    n_chk++; if (idle_err != 0) $display("FAIL sparse_idle got %0d want 0", idle_err); else n_pass++;
    n_chk++; if (held_err != 0) $display("FAIL sparse_held got %0d want 0", held_err); else n_pass++;
    n_chk++; if (TxD !== 1'b0) $display("FAIL sparse_start got %b want 0", TxD); else n_pass++;
    rx_frame(-1, -1);
    n_chk++; if (rx_bytes[32] !== 8'h0F) $display("FAIL sparse_last got %h want 0f", rx_bytes[32]); else n_pass++;
    n_chk++; if (done_seen !== 1'b1) $display("FAIL sparse_done got %b want 1", done_seen); else n_pass++;
    step();
  endtask

  task automatic test_overflow();
    int bad;
    for (int i = 0; i < NW; i++) wv[i] = 16'h1000 + 16'(i);
    send_words(0);
    n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_pre got %b want 0", overflow); else n_pass++;
    rx_frame(100, 700);
    bad = 0;
    for (int k = 0; k < NB; k++) if (rx_bytes[k] !== exp_byte(k)) bad++;
    n_chk++; if (bad != 0) $display("FAIL ovf_bytes got %0d bad want 0", bad); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
    n_chk++; if (words_held !== 5'd16) $display("FAIL ovf_held_send got %0d want 16", words_held); else n_pass++;
    n_chk++; if (done_seen !== 1'b1) $display("FAIL ovf_done got %b want 1", done_seen); else n_pass++;
    step();
    n_chk++; if (words_held !== 5'd0) $display("FAIL ovf_held_clr got %0d want 0", words_held); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
    for (int i = 0; i < NW; i++) wv[i] = 16'h2000 + 16'(i * 3);
    send_words(1);
    rx_frame(-1, -1);
    bad = 0;
    for (int k = 0; k < NB; k++) if (rx_bytes[k] !== exp_byte(k)) bad++;
    n_chk++; if (bad != 0) $display("FAIL ovf_next_frame got %0d bad want 0", bad); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky2 got %b want 1", overflow); else n_pass++;
    step();
  endtask

  task automatic test_mid_reset();
    int bad;
    for (int i = 0; i < NW; i++) wv[i] = 16'hFFFF;
    send_words(0);
    repeat (4 * 10 * CPB + 10) step();
    RST = 1'b1;
    result_valid = 1'b1;
    result_in = 16'hBEEF;
    step();
    RST = 1'b0;
    result_valid = 1'b0;
    n_chk++; if (TxD !== 1'b1) $display("FAIL mrst_txd got %b want 1", TxD); else n_pass++;
    n_chk++; if (words_held !== 5'd0) $display("FAIL mrst_held got %0d want 0", words_held); else n_pass++;
    n_chk++; if (tx_busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", tx_busy); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL mrst_ovf got %b want 0", overflow); else n_pass++;
    bad = 0;
    for (int i = 0; i < FL + 40; i++) begin
      step();
      if (frame_done !== 1'b0 || TxD !== 1'b1) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL mrst_quiet got %0d bad cycles want 0", bad); else n_pass++;
    for (int i = 0; i < NW; i++) wv[i] = 16'h3000 + 16'(i * 257);
    send_words(0);
    rx_frame(-1, -1);
    bad = 0;
    for (int k = 0; k < NB; k++) if (rx_bytes[k] !== exp_byte(k)) bad++;
    n_chk++; if (bad != 0) $display("FAIL mrst_frame got %0d bad want 0", bad); else n_pass++;
    n_chk++; if (done_seen !== 1'b1) $display("FAIL mrst_done got %b want 1", done_seen); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bit_timing();
    test_sparse();
    test_overflow();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
